// File: rtl/nave_multitiro.sv
// nave_multitiro: player ship with a pool of N_TIROS independent allied shots.
// Ship and shot motion advance once per game tick (every DIV_TICK clocks) and
// freeze while pausa is high. Shot hit strobes (acerto) act on every clock.
//
// Optional feature macro: NAVE_AUTOFIRE_EN
//   defined   -> fire request is the keysout[1] level (repeat fire on cooldown)
//   undefined -> fire request is a rising edge of keysout[1] sampled on ticks
//
// Ports:
//   CLOCK_50       system clock
//   reset          asynchronous active-high reset
//   keysout[3:0]   [0]=right, [1]=fire, [2]=left, [3] unused
//   pausa          freezes tick counter and all motion
//   reiniciarJogo  synchronous restart to reset state (highest priority)
//   acerto         per-slot hit strobe, clears that slot's ativo bit
//   largura_nave, altura_nave, raio_tiro   constant geometry
//   x_nave, y_nave                         ship top-left
//   x_tiros, y_tiros                       slot i centre at [10i+9:10i]
//   ativo                                  slot i holds a live shot
//   disparo                                one-clock pulse on shot launch
module nave_multitiro #(
  parameter int N_TIROS    = 4,
  parameter int LARGURA    = 30,
  parameter int ALTURA     = 30,
  parameter int X_INICIAL  = 350,
  parameter int Y_INICIAL  = 420,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 640,
  parameter int DIV_TICK   = 250000,
  parameter int PASSO_NAVE = 2,
  parameter int PASSO_TIRO = 4,
  parameter int RECARGA    = 20,
  parameter int RAIO       = 3
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [3:0]              keysout,
  input  logic                    pausa,
  input  logic                    reiniciarJogo,
  input  logic [N_TIROS-1:0]      acerto,
  output logic [9:0]              largura_nave,
  output logic [9:0]              altura_nave,
  output logic [9:0]              x_nave,
  output logic [9:0]              y_nave,
  output logic [10*N_TIROS-1:0]   x_tiros,
  output logic [10*N_TIROS-1:0]   y_tiros,
  output logic [N_TIROS-1:0]      ativo,
  output logic [9:0]              raio_tiro,
  output logic                    disparo
);

  localparam int CW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
  localparam int RW = (RECARGA > 0) ? $clog2(RECARGA + 1) : 1;

  localparam logic [CW-1:0] CNT_FIM   = CW'(DIV_TICK - 1);
  localparam logic [RW-1:0] RECARGA_V = RW'(RECARGA);
  localparam logic [9:0]    X_LIM     = 10'(X_MAX - LARGURA);
  localparam logic [9:0]    X_LO      = 10'(X_MIN);
  localparam logic [9:0]    X_INI     = 10'(X_INICIAL);
  localparam logic [9:0]    Y_INI     = 10'(Y_INICIAL);
  localparam logic [9:0]    PN        = 10'(PASSO_NAVE);
  localparam logic [9:0]    PT        = 10'(PASSO_TIRO);
  localparam logic [9:0]    MEIA      = 10'(LARGURA / 2);

  logic [CW-1:0]      cnt;
  logic [RW-1:0]      recarga;
  logic               tick;
  logic               avanca;
  logic               pedido;
  logic [N_TIROS-1:0] livre;
  logic               tem_livre;
  logic               lanca;
  logic [10:0]        x_soma;
  logic [9:0]         x_prox;
  logic               unused_tecla;

`ifndef NAVE_AUTOFIRE_EN
  logic               fire_prev;
`endif

  assign largura_nave = 10'(LARGURA);
  assign altura_nave  = 10'(ALTURA);
  assign raio_tiro    = 10'(RAIO);
  assign y_nave       = Y_INI;
  assign unused_tecla = keysout[3];

  always_comb begin
    tick   = (cnt == CNT_FIM);
    avanca = tick && !pausa;

`ifdef NAVE_AUTOFIRE_EN
    pedido = keysout[1];
`else
    pedido = keysout[1] && !fire_prev;
`endif

    // One-hot pick of the lowest free slot; a slot being hit this cycle
    // is not eligible even though its ativo bit is already low.
    livre     = '0;
    tem_livre = 1'b0;
    for (int unsigned i = 0; i < N_TIROS; i++) begin
      if (!tem_livre && !ativo[i] && !acerto[i]) begin
        livre[i]  = 1'b1;
        tem_livre = 1'b1;
      end
    end
    lanca = avanca && pedido && (recarga == '0) && tem_livre;

    // Widened arithmetic so saturation never wraps at either edge.
    x_soma = {1'b0, x_nave} + {1'b0, PN};
    x_prox = x_nave;
    case ({keysout[2], keysout[0]})
      2'b01:   x_prox = (x_soma >= {1'b0, X_LIM}) ? X_LIM : x_soma[9:0];
      2'b10:   x_prox = ({1'b0, x_nave} < ({1'b0, X_LO} + {1'b0, PN})) ? X_LO : x_nave - PN;
      default: x_prox = x_nave;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      recarga   <= '0;
      x_nave    <= X_INI;
      ativo     <= '0;
      x_tiros   <= '0;
      y_tiros   <= '0;
      disparo   <= 1'b0;
`ifndef NAVE_AUTOFIRE_EN
      fire_prev <= 1'b0;
`endif
    end else if (reiniciarJogo) begin
      cnt       <= '0;
      recarga   <= '0;
      x_nave    <= X_INI;
      ativo     <= '0;
      x_tiros   <= '0;
      y_tiros   <= '0;
      disparo   <= 1'b0;
`ifndef NAVE_AUTOFIRE_EN
      fire_prev <= 1'b0;
`endif
    end else begin
      disparo <= lanca;
      if (!pausa) begin
        cnt <= tick ? '0 : cnt + CW'(1);
      end
      if (avanca) begin
        x_nave <= x_prox;
`ifndef NAVE_AUTOFIRE_EN
        fire_prev <= keysout[1];
`endif
        if (lanca) begin
          recarga <= RECARGA_V;
        end else if (recarga != '0) begin
          recarga <= recarga - RW'(1);
        end
      end
      for (int unsigned i = 0; i < N_TIROS; i++) begin
        if (acerto[i]) begin
          ativo[i] <= 1'b0;
        end else if (avanca) begin
          if (lanca && livre[i]) begin
            ativo[i]            <= 1'b1;
            x_tiros[10*i +: 10] <= x_nave + MEIA;
            y_tiros[10*i +: 10] <= Y_INI;
          end else if (ativo[i]) begin
            // Retire instead of stepping below zero.
            if (y_tiros[10*i +: 10] < PT) begin
              ativo[i] <= 1'b0;
            end else begin
              y_tiros[10*i +: 10] <= y_tiros[10*i +: 10] - PT;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nave_multitiro.sv
module tb_nave_multitiro;

  localparam int N = 4;

  logic            CLOCK_50 = 1'b0;
  logic            reset;
  logic [3:0]      keysout;
  logic            pausa;
  logic            reiniciarJogo;
  logic [N-1:0]    acerto;
  logic [9:0]      largura_nave, altura_nave, x_nave, y_nave, raio_tiro;
  logic [10*N-1:0] x_tiros, y_tiros;
  logic [N-1:0]    ativo;
  logic            disparo;

  nave_multitiro #(
    .N_TIROS(N), .DIV_TICK(4), .PASSO_NAVE(2), .PASSO_TIRO(4), .RECARGA(3)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .keysout(keysout), .pausa(pausa),
    .reiniciarJogo(reiniciarJogo), .acerto(acerto),
    .largura_nave(largura_nave), .altura_nave(altura_nave),
    .x_nave(x_nave), .y_nave(y_nave), .x_tiros(x_tiros), .y_tiros(y_tiros),
    .ativo(ativo), .raio_tiro(raio_tiro), .disparo(disparo)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  typedef struct { string nome; logic [31:0] valor; } esp_t;
  esp_t fila[$];

  typedef struct { logic [3:0] keys; int n; int x; } vet_t;
  vet_t tab[10];

`ifdef NAVE_AUTOFIRE_EN
  localparam int TIROS_SEGURANDO = 3;
  localparam int ATIVO_SEGURANDO = 4'b0111;
`else
  localparam int TIROS_SEGURANDO = 1;
  localparam int ATIVO_SEGURANDO = 4'b0001;
`endif

  task automatic espera(input string nome, input logic [31:0] v);
    esp_t e;
    e.nome  = nome;
    e.valor = v;
    fila.push_back(e);
  endtask

  task automatic confere(input logic [31:0] atual);
    esp_t e;
    checks++;
    if (fila.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got=%0d", atual);
    end else begin
      e = fila.pop_front();
      if (atual !== e.valor) begin
        errors++;
        $display("FAIL %s got=%0d expected=%0d", e.nome, atual, e.valor);
      end
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic ticks(input int n);
    clk(4 * n);
  endtask

  function automatic logic [9:0] xt(input int i);
    return x_tiros[10*i +: 10];
  endfunction

  function automatic logic [9:0] yt(input int i);
    return y_tiros[10*i +: 10];
  endfunction

  task automatic do_reset();
    reset = 1'b1; keysout = '0; pausa = 1'b0; reiniciarJogo = 1'b0; acerto = '0;
    clk(2);
    reset = 1'b0;
  endtask

  // One tick with fire held, then release for `resto` ticks.
  task automatic tiro(input int resto, input logic disp_esp, input logic [3:0] ativo_esp);
    keysout = 4'b0010;
    espera("fire_disparo", 32'(disp_esp));
    espera("fire_ativo", 32'(ativo_esp));
    ticks(1);
    confere(32'(disparo));
    confere(32'(ativo));
    keysout = 4'b0000;
    if (resto > 0) ticks(resto);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulsos;
    tab[0] = '{4'b0001,   1, 610};
    tab[1] = '{4'b0100,   1, 608};
    tab[2] = '{4'b0101,   3, 608};
    tab[3] = '{4'b0000,   2, 608};
    tab[4] = '{4'b1000,   2, 608};
    tab[5] = '{4'b0100,  10, 588};
    tab[6] = '{4'b0001,   4, 596};
    tab[7] = '{4'b0100, 310,   0};
    tab[8] = '{4'b0100,   1,   0};
    tab[9] = '{4'b0001,   1,   2};

    // Reset state, sampled while reset is still held.
    reset = 1'b1; keysout = '0; pausa = 1'b0; reiniciarJogo = 1'b0; acerto = '0;
    clk(2);
    espera("rst_x_nave", 350);  confere(32'(x_nave));
    espera("rst_y_nave", 420);  confere(32'(y_nave));
    espera("rst_ativo", 0);     confere(32'(ativo));
    espera("rst_disparo", 0);   confere(32'(disparo));
    espera("rst_x_tiros", 0);   confere(x_tiros[31:0]);
    espera("rst_y_tiros", 0);   confere(y_tiros[31:0]);
    espera("largura", 30);      confere(32'(largura_nave));
    espera("raio", 3);          confere(32'(raio_tiro));
    reset = 1'b0;

    // Ship held right: climbs by 2 per tick and saturates at 610.
    keysout = 4'b0001;
    for (int k = 1; k <= 200; k++) begin
      int e;
      e = 350 + 2 * k;
      if (e > 610) e = 610;
      espera("ship_right", 32'(e));
      ticks(1);
      confere(32'(x_nave));
    end

    // Table of movement vectors continuing from x=610.
    for (int i = 0; i < 10; i++) begin
      keysout = tab[i].keys;
      espera("tab_x_nave", 32'(tab[i].x));
      espera("tab_ativo", 0);
      ticks(tab[i].n);
      confere(32'(x_nave));
      confere(32'(ativo));
    end

    // Single shot from x=350.
    do_reset();
    keysout = 4'b0010;
    espera("b_disparo", 1);  espera("b_ativo", 1);
    espera("b_x0", 365);     espera("b_y0", 420);
    ticks(1);
    confere(32'(disparo)); confere(32'(ativo));
    confere(32'(xt(0)));   confere(32'(yt(0)));
    keysout = 4'b0000;
    espera("b_disparo_one_clock", 0);
    clk(1);
    confere(32'(disparo));
    espera("b_y0_next", 416); espera("b_x0_next", 365);
    clk(3);
    confere(32'(yt(0))); confere(32'(xt(0)));

    // Fill all slots, fifth request finds none free.
    do_reset();
    tiro(4, 1'b1, 4'b0001);
    tiro(4, 1'b1, 4'b0011);
    tiro(4, 1'b1, 4'b0111);
    tiro(4, 1'b1, 4'b1111);
    tiro(4, 1'b0, 4'b1111);
    espera("c_y0_t25", 324); espera("c_y3_t25", 384); espera("c_x3", 365);
    confere(32'(yt(0))); confere(32'(yt(3))); confere(32'(xt(3)));
    ticks(81);
    espera("c_y0_zero", 0); espera("c_ativo_t106", 4'b1111);
    confere(32'(yt(0))); confere(32'(ativo));
    ticks(1);
    espera("c_ativo_retired", 4'b1110); espera("c_y0_held", 0); espera("c_y1_t107", 16);
    confere(32'(ativo)); confere(32'(yt(0))); confere(32'(yt(1)));

    // Cooldown: request two ticks later is dropped, later one launches.
    do_reset();
    tiro(1, 1'b1, 4'b0001);
    tiro(1, 1'b0, 4'b0001);
    tiro(0, 1'b1, 4'b0011);

    // Hit during pause; everything else frozen.
    do_reset();
    tiro(3, 1'b1, 4'b0001);
    tiro(0, 1'b1, 4'b0011);
    pausa = 1'b1;
    clk(2);
    acerto = 4'b0010;
    espera("e_hit_paused", 4'b0001);
    clk(1);
    confere(32'(ativo));
    acerto = 4'b0100;
    espera("e_hit_inactive", 4'b0001);
    clk(1);
    confere(32'(ativo));
    acerto = '0;
    keysout = 4'b0001;
    clk(4);
    espera("e_y0_frozen", 404); espera("e_x_frozen", 350);
    confere(32'(yt(0))); confere(32'(x_nave));
    keysout = 4'b0000;
    pausa = 1'b0;
    clk(3);
    espera("e_cnt_frozen", 404);
    confere(32'(yt(0)));
    clk(1);
    espera("e_y0_resume", 400); espera("e_ativo_resume", 4'b0001);
    confere(32'(yt(0))); confere(32'(ativo));

    // Restart with three live shots.
    do_reset();
    tiro(3, 1'b1, 4'b0001);
    tiro(3, 1'b1, 4'b0011);
    tiro(0, 1'b1, 4'b0111);
    keysout = 4'b0001;
    ticks(2);
    espera("f_x_moved", 354);
    confere(32'(x_nave));
    keysout = 4'b0000;
    clk(2);
    reiniciarJogo = 1'b1;
    espera("f_x", 350); espera("f_ativo", 0); espera("f_xt", 0);
    espera("f_yt", 0);  espera("f_disparo", 0);
    clk(1);
    confere(32'(x_nave)); confere(32'(ativo)); confere(x_tiros[31:0]);
    confere(y_tiros[31:0]); confere(32'(disparo));
    reiniciarJogo = 1'b0;
    keysout = 4'b0010;
    pulsos = 0;
    for (int c = 0; c < 48; c++) begin
      clk(1);
      if (disparo) pulsos++;
    end
    espera("f_hold_shots", 32'(TIROS_SEGURANDO));
    espera("f_hold_ativo", 32'(ATIVO_SEGURANDO));
    confere(32'(pulsos)); confere(32'(ativo));

    // Asynchronous reset mid-tick.
    keysout = 4'b0001;
    ticks(2);
    espera("g_x_before", 354);
    confere(32'(x_nave));
    clk(2);
    reset = 1'b1;
    #2;
    espera("g_async_x", 350); espera("g_async_ativo", 0);
    confere(32'(x_nave)); confere(32'(ativo));
    reset = 1'b0;
    keysout = '0;

    if (fila.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", fila.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nave_multitiro.md
# nave_multitiro

Player-ship controller with a pool of independent shots, the next generation of the single-shot ship block. It owns the ship position and up to N_TIROS simultaneous allied shots. Motion advances on an internal game tick rather than every clock. It sits between the keypad decoder (keysout, pausa, reiniciarJogo) and the renderer/collision logic, which consume the flattened shot buses and return per-shot hit strobes.

## Interface
- N_TIROS, 4: shot slots (1..8)
- LARGURA / ALTURA, 30 / 30: ship size in px
- X_INICIAL / Y_INICIAL, 350 / 420: ship position after reset/restart
- X_MIN / X_MAX, 0 / 640: horizontal limits; ship kept in [X_MIN, X_MAX−LARGURA]
- DIV_TICK, 250000: clocks per game tick (200 Hz at 50 MHz)
- PASSO_NAVE, 2: ship px per tick
- PASSO_TIRO, 4: shot px per tick (upward)
- RECARGA, 20: ticks of cooldown after a shot
- RAIO, 3: shot radius
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- keysout  in  4  [0]=right, [2]=left, [1]=fire, [3] unused
- pausa  in  1  freezes tick counter and all motion
- reiniciarJogo  in  1  synchronous restart to reset state
- acerto  in  N_TIROS  per-slot hit strobe from collision logic
- largura_nave, altura_nave  out  10  constants LARGURA, ALTURA
- x_nave, y_nave  out  10  ship top-left
- x_tiros, y_tiros  out  10*N_TIROS  slot i at bits [10i+9:10i], shot centre
- ativo  out  N_TIROS  slot i holds a live shot
- raio_tiro  out  10  constant RAIO
- disparo  out  1  one-cycle pulse when a shot launches

## Operation
- Reset and reiniciarJogo give x_nave=X_INICIAL, y_nave=Y_INICIAL, ativo=0, x_tiros=y_tiros=0, cooldown=0, tick counter=0, disparo=0, fire-edge history=0. Restart takes precedence over everything else.
- The tick counter runs 0..DIV_TICK−1. `tick` is asserted on the cycle the count is DIV_TICK−1, and the counter holds while pausa=1. All following updates happen only on tick cycles with pausa=0.
- Ship:
  - right only: x = min(x+PASSO_NAVE, X_MAX−LARGURA).
  - left only: x = max(x−PASSO_NAVE, X_MIN).
  - both or neither: hold.
  - Saturating, never wraps. y_nave is constant.
- Shots: each active slot updates y −= PASSO_TIRO. If y < PASSO_TIRO before the update, the slot deactivates instead and y holds (no unsigned wrap).
- Fire request:
  - Rising edge of keysout[1], using a history bit updated on ticks only.
  - The request launches a shot when cooldown==0 and a free slot exists.
  - The chosen slot is the lowest index with ativo=0 and acerto=0.
  - The new shot gets x = x_nave(pre-move) + LARGURA/2 and y = y_nave, ativo=1, and does not move on its launch tick.
  - Launch sets cooldown=RECARGA and pulses disparo.
  - A request while cooldown≠0 or with no free slot is dropped, not queued.
- Firing and movement are concurrent on the same tick.
- Cooldown decrements by 1 per tick while nonzero.
- acerto[i] clears ativo[i] on any clock edge, including during pausa and off-tick. It wins over motion on the same cycle. acerto on an inactive slot has no effect.

## Timing
- All outputs are registered. Updates appear on the clock edge that ends the tick cycle.
- Latency from keysout to position/launch: up to DIV_TICK clocks (sampled on tick only).
- disparo is high for exactly one clock, coincident with the new ativo bit.
- acerto takes effect 1 clock after assertion.
- Reset is asynchronous. Mid-tick reset abandons the tick, and outputs return to reset values immediately.

## Configuration
- NAVE_AUTOFIRE_EN defined: fire request = keysout[1] level. Holding fire launches a shot every RECARGA+1 ticks while slots are free.
- NAVE_AUTOFIRE_EN undefined: fire request = rising edge only. Holding fire yields exactly one shot.

## Test plan
All scenarios use DIV_TICK=4, PASSO_NAVE=2, PASSO_TIRO=4, RECARGA=3.
- Reset, then hold keysout[0] for 200 ticks -> x_nave climbs 350,352,… and saturates at 610; never wraps.
- Press fire once at x_nave=350 -> disparo pulse; slot0 at (365,420), ativo=4'b0001; next tick y=416.
- Fire edges every 5 ticks, with no acerto, until all 4 slots are used -> slots fill 0..3; the 5th edge gives no disparo; a shot reaching y<4 clears its ativo bit.
- Fire edges 2 ticks apart -> second is dropped (cooldown); next edge after cooldown reaches 0 launches.
- Pulse acerto[1] while pausa=1 -> ativo[1] clears next clock; positions and tick counter are frozen.
- Assert reiniciarJogo with 3 shots live -> next clock all outputs equal reset values; with NAVE_AUTOFIRE_EN, holding fire then yields shots every 4 ticks.
